// File: rtl/mips_isa_pkg.sv
// -----------------------------------------------------------------------------
// mips_isa_pkg
// Shared MIPS instruction-set constants for the encoder (and the decoder side):
//   - kind_t   : mnemonic codes accepted on the encoder record interface
//   - OP_* / FN_* : primary opcodes and R-type funct codes
//   - state_t  : sequencer state encoding of mips_instr_encoder
//   - kind_is_legal() : true for the mnemonic codes the encoder can pack
// Optional feature macro used by the encoder: ENC_NOP_PAD_EN (enables ST_PAD).
// -----------------------------------------------------------------------------
package mips_isa_pkg;

   localparam int KIND_W = 4;

   typedef enum logic [KIND_W-1:0] {
      K_ADD  = 4'd0,
      K_SUB  = 4'd1,
      K_AND  = 4'd2,
      K_OR   = 4'd3,
      K_SLT  = 4'd4,
      K_LW   = 4'd5,
      K_SW   = 4'd6,
      K_BEQ  = 4'd7,
      K_ADDI = 4'd8,
      K_J    = 4'd9
   } kind_t;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct codes
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // ST_PAD is only reachable when ENC_NOP_PAD_EN is defined.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_FULL = 2'd2,
      ST_PAD  = 2'd3
   } state_t;

   function automatic logic kind_is_legal(input logic [KIND_W-1:0] k);
      return (k <= K_J);
   endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// -----------------------------------------------------------------------------
// mips_instr_encoder_if
// Record handshake between a program source and the instruction encoder.
//   in_valid  : record valid (source -> encoder)
//   in_ready  : encoder accepts this cycle (encoder -> source)
//   in_kind   : mnemonic code, see mips_isa_pkg::kind_t (10..15 are illegal)
//   in_rs, in_rt, in_rd : register fields
//   in_imm    : 16-bit immediate / branch offset
//   in_target : 26-bit jump target
// Modports: master = record source, slave = encoder.
// -----------------------------------------------------------------------------
interface mips_instr_encoder_if;
   import mips_isa_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [KIND_W-1:0] in_kind;
   logic [4:0]        in_rs;
   logic [4:0]        in_rt;
   logic [4:0]        in_rd;
   logic [15:0]       in_imm;
   logic [25:0]       in_target;

   modport master (
      output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target,
      output in_ready
   );

endinterface

// File: rtl/mips_word_pack.sv
// -----------------------------------------------------------------------------
// mips_word_pack
// Purely combinational packer: mnemonic code + fields -> 32-bit MIPS word.
// Ports:
//   kind   in  4   mnemonic code (mips_isa_pkg::kind_t, 10..15 illegal)
//   rs, rt, rd in 5 register fields
//   imm    in  16  immediate (I-type only)
//   target in  26  jump target (J only)
//   word   out 32  packed instruction (zero for illegal codes)
//   legal  out 1   kind is one of the supported mnemonics
// Fields not used by a format are ignored.
// -----------------------------------------------------------------------------
module mips_word_pack
   import mips_isa_pkg::*;
(
   input  logic [KIND_W-1:0] kind,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [15:0]       imm,
   input  logic [25:0]       target,
   output logic [31:0]       word,
   output logic              legal
);

   always_comb begin
      word  = 32'h0000_0000;
      legal = kind_is_legal(kind);
      case (kind)
         K_ADD:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
         K_SUB:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
         K_AND:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
         K_OR:    word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
         K_SLT:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
         K_LW:    word = {OP_LW,    rs, rt, imm};
         K_SW:    word = {OP_SW,    rs, rt, imm};
         K_BEQ:   word = {OP_BEQ,   rs, rt, imm};
         K_ADDI:  word = {OP_ADDI,  rs, rt, imm};
         K_J:     word = {OP_J,     target};
         default: word = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/mips_instr_encoder.sv
// -----------------------------------------------------------------------------
// mips_instr_encoder
// Streaming instruction encoder / program writer. Accepts one record per
// valid/ready handshake, packs it into a MIPS word and writes it to the next
// sequential imem address one cycle later.
// Parameters:
//   ADDR_W : imem word-address width
//   DEPTH  : number of words writable before full (DEPTH <= 2**ADDR_W)
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   start           : pulse - clear pointer/count/err and (re)enter LOAD
//   finish          : (ENC_NOP_PAD_EN only) pad remaining words with NOPs
//   rec             : record handshake (mips_instr_encoder_if.slave)
//   imem_we/addr/wdata : imem write port, held when imem_we=0
//   count           : words written since start
//   full            : count == DEPTH
//   err             : sticky, an illegal kind was accepted and dropped
// Optional feature macro: ENC_NOP_PAD_EN.
// -----------------------------------------------------------------------------
module mips_instr_encoder #(
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
`ifdef ENC_NOP_PAD_EN
   input  logic                finish,
`endif
   mips_instr_encoder_if.slave rec,
   output logic                imem_we,
   output logic [ADDR_W-1:0]   imem_addr,
   output logic [31:0]         imem_wdata,
   output logic [ADDR_W:0]     count,
   output logic                full,
   output logic                err
);
   import mips_isa_pkg::*;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   state_t            state;
   logic [ADDR_W-1:0] wr_ptr;
   logic              accept;
   logic              last_slot;
   logic [31:0]       pack_word;
   logic              pack_legal;

   // Ready depends only on registered state and start, never on in_valid.
   assign rec.in_ready = (state == ST_LOAD) && !start;
   assign accept       = rec.in_valid && rec.in_ready;
   assign full         = (count == DEPTH_C);
   // The next write consumes the final slot.
   assign last_slot    = (count == DEPTH_C - (ADDR_W+1)'(1));

   mips_word_pack u_pack (
      .kind   (rec.in_kind),
      .rs     (rec.in_rs),
      .rt     (rec.in_rt),
      .rd     (rec.in_rd),
      .imm    (rec.in_imm),
      .target (rec.in_target),
      .word   (pack_word),
      .legal  (pack_legal)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         wr_ptr     <= '0;
         count      <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= 32'h0000_0000;
         err        <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         if (start) begin
            state  <= ST_LOAD;
            wr_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: ;
               ST_LOAD: begin
                  if (accept) begin
                     if (pack_legal) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= wr_ptr;
                        imem_wdata <= pack_word;
                        wr_ptr     <= wr_ptr + ADDR_W'(1);
                        count      <= count + (ADDR_W+1)'(1);
                        if (last_slot) state <= ST_FULL;
                     end else begin
                        // Illegal record: handshake completes, nothing written.
                        err <= 1'b1;
                     end
                  end
`ifdef ENC_NOP_PAD_EN
                  // A record accepted with finish still gets written; if it
                  // takes the last slot the FULL transition above stands.
                  if (finish && !(accept && pack_legal && last_slot)) begin
                     state <= ST_PAD;
                  end
`endif
               end
`ifdef ENC_NOP_PAD_EN
               ST_PAD: begin
                  imem_we    <= 1'b1;
                  imem_addr  <= wr_ptr;
                  imem_wdata <= 32'h0000_0000;
                  wr_ptr     <= wr_ptr + ADDR_W'(1);
                  count      <= count + (ADDR_W+1)'(1);
                  if (last_slot) state <= ST_FULL;
               end
`endif
               ST_FULL: ;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_mips_instr_encoder
// Self-checking bench for mips_instr_encoder: a table of records with their
// expected machine words, a write scoreboard (expected {addr, word} queued on
// accept, popped when imem_we is seen), and hand-written sequences for full,
// start/valid collision, mid-stream reset and (ENC_NOP_PAD_EN) NOP padding.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mips_instr_encoder;
   import mips_isa_pkg::*;

   localparam int ADDR_W = 6;
   localparam int DEPTH  = 64;

   typedef struct {
      logic [3:0]  kind;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [15:0] imm;
      logic [25:0] target;
      logic [31:0] word;
      logic        legal;
   } vec_t;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       word;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              finish;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              err;

   mips_instr_encoder_if rec ();

   mips_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
`ifdef ENC_NOP_PAD_EN
      .finish     (finish),
`endif
      .rec        (rec),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .count      (count),
      .full       (full),
      .err        (err)
   );

   always #5 clk = ~clk;

   int                n_vec = 0;
   int                n_bad = 0;
   exp_t              sb[$];
   exp_t              e;
   vec_t              tbl[13];
   vec_t              v;
   logic [ADDR_W-1:0] m_ptr;
   int                m_cnt;
   logic              m_err;
   logic [31:0]       m_last;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Write monitor: every imem write must match the head of the scoreboard.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", imem_addr, imem_wdata);
         end else begin
            e = sb.pop_front();
            chk("wr_addr", 32'(imem_addr), 32'(e.addr));
            chk("wr_data", imem_wdata, e.word);
         end
      end
   end

   task automatic model_clear();
      m_ptr = '0;
      m_cnt = 0;
      m_err = 1'b0;
   endtask

   task automatic drive(input vec_t x);
      rec.in_kind   = x.kind;
      rec.in_rs     = x.rs;
      rec.in_rt     = x.rt;
      rec.in_rd     = x.rd;
      rec.in_imm    = x.imm;
      rec.in_target = x.target;
   endtask

   // Present a record and wait (bounded) for ready; queue the expected write.
   task automatic offer(input vec_t x, input int maxw);
      int w;
      w = 0;
      @(negedge clk);
      start = 1'b0;
      drive(x);
      rec.in_valid = 1'b1;
      #1;
      while (rec.in_ready !== 1'b1 && w < maxw) begin
         @(negedge clk);
         #1;
         w++;
      end
      if (rec.in_ready !== 1'b1) begin
         n_vec++;
         n_bad++;
         $display("FAIL accept_timeout: got in_ready=%b after %0d cycles, expected 1", rec.in_ready, w);
      end else if (x.legal) begin
         sb.push_back('{addr: m_ptr, word: x.word});
         m_ptr++;
         m_cnt++;
         m_last = x.word;
      end else begin
         m_err = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rec.in_valid = 1'b0;
         start = 1'b0;
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      rec.in_valid = 1'b0;
      model_clear();
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200us, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      finish = 1'b0;
      rec.in_valid = 1'b0;
      model_clear();
      m_last = 32'h0;

      //              kind     rs     rt     rd     imm        target        word          legal
      tbl[0]  = '{4'd0,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0000000, 32'h00221820, 1'b1}; // ADD
      tbl[1]  = '{4'd5,  5'd9,  5'd8,  5'd0,  16'h0004, 26'h0000000, 32'h8D280004, 1'b1}; // LW
      tbl[2]  = '{4'd7,  5'd1,  5'd2,  5'd0,  16'hFFFF, 26'h0000000, 32'h1022FFFF, 1'b1}; // BEQ
      tbl[3]  = '{4'd9,  5'd0,  5'd0,  5'd0,  16'h0000, 26'h0000010, 32'h08000010, 1'b1}; // J
      tbl[4]  = '{4'd1,  5'd4,  5'd5,  5'd6,  16'h1234, 26'h3FFFFFF, 32'h00853022, 1'b1}; // SUB
      tbl[5]  = '{4'd2,  5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h03FFF824, 1'b1}; // AND
      tbl[6]  = '{4'd3,  5'd7,  5'd8,  5'd9,  16'h0000, 26'h0000000, 32'h00E84825, 1'b1}; // OR
      tbl[7]  = '{4'd4,  5'd10, 5'd11, 5'd12, 16'h0000, 26'h0000000, 32'h014B602A, 1'b1}; // SLT
      tbl[8]  = '{4'd6,  5'd29, 5'd31, 5'd7,  16'h8000, 26'h0000000, 32'hAFBF8000, 1'b1}; // SW
      tbl[9]  = '{4'd12, 5'd1,  5'd2,  5'd3,  16'h5555, 26'h0000000, 32'h00000000, 1'b0}; // illegal
      tbl[10] = '{4'd8,  5'd0,  5'd5,  5'd0,  16'h0007, 26'h0000000, 32'h20050007, 1'b1}; // ADDI
      tbl[11] = '{4'd9,  5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h0BFFFFFF, 1'b1}; // J max
      tbl[12] = '{4'd15, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h0000000, 32'h00000000, 1'b0}; // illegal
      drive(tbl[0]);

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_we", 32'(imem_we), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_wdata", imem_wdata, 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_ready", 32'(rec.in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // IDLE never accepts
      @(negedge clk);
      rec.in_valid = 1'b1;
      @(negedge clk);
      #1;
      chk("idle_ready", 32'(rec.in_ready), 32'd0);
      rec.in_valid = 1'b0;

      // First record: write appears the cycle after accept
      pulse_start();
      offer(tbl[0], 4);
      idle(1);
      chk("first_we", 32'(imem_we), 32'd1);
      chk("first_count", 32'(count), 32'd1);

      // Remaining table entries back-to-back
      for (int i = 1; i < 13; i++) offer(tbl[i], 4);
      idle(1);
      chk("tbl_count", 32'(count), 32'(m_cnt));
      chk("tbl_err", 32'(err), 32'(m_err));
      idle(1);
      chk("hold_we", 32'(imem_we), 32'd0);
      chk("hold_wdata", imem_wdata, m_last);
      chk("hold_addr", 32'(imem_addr), 32'(m_ptr - 1'b1));

      // start clears count and err
      pulse_start();
      #1;
      chk("start_count", 32'(count), 32'd0);
      chk("start_err", 32'(err), 32'd0);
      chk("start_full", 32'(full), 32'd0);

      // Fill to DEPTH, then verify hold-off
      for (int i = 0; i < DEPTH; i++) begin
         v = '{4'd8, 5'd0, 5'd1, 5'd0, 16'(i), 26'h0, 32'h20010000 | 32'(i), 1'b1};
         offer(v, 4);
      end
      idle(1);
      #1;
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count", 32'(count), 32'(DEPTH));
      chk("fill_ready", 32'(rec.in_ready), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         rec.in_valid = 1'b1;
         #1;
         chk("full_holdoff", 32'(rec.in_ready), 32'd0);
      end
      idle(1);
      chk("fill_sb_empty", 32'(sb.size()), 32'd0);

      // start and in_valid together: record taken only on the following cycle
      @(negedge clk);
      start = 1'b1;
      model_clear();
      drive(tbl[0]);
      rec.in_valid = 1'b1;
      #1;
      chk("start_valid_ready", 32'(rec.in_ready), 32'd0);
      offer(tbl[0], 4);
      idle(1);
      chk("restart_count", 32'(count), 32'd1);
      chk("restart_full", 32'(full), 32'd0);

      // Reset in the middle of a stream
      offer(tbl[1], 4);
      offer(tbl[9], 4);
      @(negedge clk);
      drive(tbl[2]);
      rec.in_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("pre_rst_err", 32'(err), 32'd1);
      @(negedge clk);
      #1;
      model_clear();
      chk("midrst_we", 32'(imem_we), 32'd0);
      chk("midrst_addr", 32'(imem_addr), 32'd0);
      chk("midrst_wdata", imem_wdata, 32'd0);
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_full", 32'(full), 32'd0);
      chk("midrst_err", 32'(err), 32'd0);
      chk("midrst_ready", 32'(rec.in_ready), 32'd0);
      rst_n = 1'b1;
      rec.in_valid = 1'b0;
      pulse_start();
      offer(tbl[4], 4);
      offer(tbl[5], 4);
      idle(1);
      chk("post_rst_count", 32'(count), 32'd2);

`ifdef ENC_NOP_PAD_EN
      // Three words then finish: remaining addresses padded with zero
      pulse_start();
      offer(tbl[0], 4);
      offer(tbl[1], 4);
      offer(tbl[2], 4);
      @(negedge clk);
      rec.in_valid = 1'b0;
      finish = 1'b1;
      for (int a = 3; a < DEPTH; a++) sb.push_back('{addr: ADDR_W'(a), word: 32'h0});
      @(negedge clk);
      finish = 1'b0;
      #1;
      chk("pad_ready", 32'(rec.in_ready), 32'd0);
      begin
         int w;
         w = 0;
         while (full !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
         end
      end
      chk("pad_full", 32'(full), 32'd1);
      chk("pad_count", 32'(count), 32'(DEPTH));
      idle(2);
`endif

      idle(3);
      chk("final_sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
